// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the IF/MEM memory-port arbiter.
// The optional timeout watchdog is enabled with MEM_ARB_TIMEOUT_EN.
package mem_port_arbiter_pkg;

  localparam int unsigned ADDR_W      = 30;
  localparam int unsigned DATA_W      = 32;
  localparam int unsigned BE_W        = 4;
  localparam int unsigned TIMEOUT_DEF = 255;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_INST = 2'd1,
    ARB_DATA = 2'd2,
    ARB_DONE = 2'd3
  } arb_state_t;

  // True while an access is outstanding on the memory port.
  function automatic logic is_wait(arb_state_t s);
    return (s == ARB_INST) || (s == ARB_DATA);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester (IF/MEM) and memory-port signals of the arbiter.
// slave = arbiter side, master = pipeline/memory environment side.
interface mem_port_arbiter_if
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ADDR_W,
  parameter int unsigned DATA_WIDTH = DATA_W
);

  logic                  InstMem_Read;
  logic [ADDR_WIDTH-1:0] InstMem_Address;
  logic                  InstMem_Ready;
  logic [DATA_WIDTH-1:0] InstMem_Data;

  logic                  DataMem_Read;
  logic                  DataMem_Write;
  logic [ADDR_WIDTH-1:0] DataMem_Address;
  logic [DATA_WIDTH-1:0] DataMem_WriteData;
  logic [BE_W-1:0]       DataMem_ByteEn;
  logic                  DataMem_Ready;
  logic [DATA_WIDTH-1:0] DataMem_ReadData;
  logic                  MEM_Stall_Controller;

  logic                  Mem_Req;
  logic                  Mem_We;
  logic [ADDR_WIDTH-1:0] Mem_Address;
  logic [DATA_WIDTH-1:0] Mem_WriteData;
  logic [BE_W-1:0]       Mem_ByteEn;
  logic [DATA_WIDTH-1:0] Mem_ReadData;
  logic                  Mem_Ack;
  logic                  Mem_Error;

  modport slave (
    input  InstMem_Read, InstMem_Address,
    output InstMem_Ready, InstMem_Data,
    input  DataMem_Read, DataMem_Write, DataMem_Address, DataMem_WriteData, DataMem_ByteEn,
    output DataMem_Ready, DataMem_ReadData, MEM_Stall_Controller,
    output Mem_Req, Mem_We, Mem_Address, Mem_WriteData, Mem_ByteEn, Mem_Error,
    input  Mem_ReadData, Mem_Ack
  );

  modport master (
    output InstMem_Read, InstMem_Address,
    input  InstMem_Ready, InstMem_Data,
    output DataMem_Read, DataMem_Write, DataMem_Address, DataMem_WriteData, DataMem_ByteEn,
    input  DataMem_Ready, DataMem_ReadData, MEM_Stall_Controller,
    input  Mem_Req, Mem_We, Mem_Address, Mem_WriteData, Mem_ByteEn, Mem_Error,
    output Mem_ReadData, Mem_Ack
  );

endinterface

// File: rtl/mem_arb_watchdog.sv
// Wait-cycle counter and sticky timeout flag for the memory-port arbiter.
// Instantiated only when MEM_ARB_TIMEOUT_EN is defined.
module mem_arb_watchdog
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic clock,
  input  logic reset_n,
  input  logic busy,
  input  logic ack,
  output logic expire_c,
  output logic error
);

  localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  logic [CNT_W-1:0] cnt;

  // Fires on the TIMEOUT-th wait cycle without an ack.
  assign expire_c = busy & ~ack & (cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt   <= '0;
      error <= 1'b0;
    end else begin
      if (busy && !ack && !expire_c) cnt <= cnt + CNT_W'(1);
      else                           cnt <= '0;
      if (expire_c) error <= 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data load/store; data has priority.
// Define MEM_ARB_TIMEOUT_EN to abort accesses that wait TIMEOUT cycles for Mem_Ack.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ADDR_W,
  parameter int unsigned DATA_WIDTH = DATA_W,
  parameter int unsigned TIMEOUT    = TIMEOUT_DEF
) (
  input logic               clock,
  input logic               reset_n,
  mem_port_arbiter_if.slave bus
);

  arb_state_t state;
  logic       abort_c;
  logic       data_req_c;

  assign data_req_c               = bus.DataMem_Read | bus.DataMem_Write;
  assign bus.MEM_Stall_Controller = data_req_c & ~bus.DataMem_Ready;

`ifdef MEM_ARB_TIMEOUT_EN
  mem_arb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clock    (clock),
    .reset_n  (reset_n),
    .busy     (is_wait(state)),
    .ack      (bus.Mem_Ack),
    .expire_c (abort_c),
    .error    (bus.Mem_Error)
  );
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign abort_c        = 1'b0;
  assign bus.Mem_Error  = 1'b0;
`endif

  // Arbiter FSM; DONE blocks re-granting a request that is still held for one cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state                <= ARB_IDLE;
      bus.Mem_Req          <= 1'b0;
      bus.Mem_We           <= 1'b0;
      bus.Mem_Address      <= '0;
      bus.Mem_WriteData    <= '0;
      bus.Mem_ByteEn       <= '0;
      bus.InstMem_Ready    <= 1'b0;
      bus.InstMem_Data     <= '0;
      bus.DataMem_Ready    <= 1'b0;
      bus.DataMem_ReadData <= '0;
    end else begin
      bus.InstMem_Ready <= 1'b0;
      bus.DataMem_Ready <= 1'b0;
      case (state)
        ARB_IDLE: begin
          if (data_req_c) begin
            state             <= ARB_DATA;
            bus.Mem_Req       <= 1'b1;
            bus.Mem_We        <= bus.DataMem_Write;
            bus.Mem_Address   <= bus.DataMem_Address;
            bus.Mem_WriteData <= bus.DataMem_WriteData;
            bus.Mem_ByteEn    <= bus.DataMem_ByteEn;
          end else if (bus.InstMem_Read) begin
            state             <= ARB_INST;
            bus.Mem_Req       <= 1'b1;
            bus.Mem_We        <= 1'b0;
            bus.Mem_Address   <= bus.InstMem_Address;
            bus.Mem_WriteData <= '0;
            bus.Mem_ByteEn    <= '0;
          end
        end
        ARB_INST, ARB_DATA: begin
          if (bus.Mem_Ack || abort_c) begin
            state       <= ARB_DONE;
            bus.Mem_Req <= 1'b0;
            bus.Mem_We  <= 1'b0;
            if (state == ARB_INST) begin
              bus.InstMem_Ready <= 1'b1;
              bus.InstMem_Data  <= bus.Mem_Ack ? bus.Mem_ReadData : '0;
            end else begin
              bus.DataMem_Ready    <= 1'b1;
              bus.DataMem_ReadData <= (bus.Mem_Ack && !bus.Mem_We) ? bus.Mem_ReadData : '0;
            end
          end
        end
        ARB_DONE: state <= ARB_IDLE;
        default:  state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a cycle-timeline transaction model.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int unsigned AW  = 30;
  localparam int unsigned DW  = 32;
  localparam int unsigned TMO = 8;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;

  int unsigned total = 0;
  int unsigned bad   = 0;

  mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus();

  mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TMO)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h want=0x%0h", tag, got, exp);
    end
  endtask

  // Model: one outstanding access, described by the cycles at which things happen.
  int          cyc = 0;
  bit          m_busy = 0, m_tgt_data = 0, m_we = 0, m_rdy_data = 0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wd = '0, m_rdy_val = '0, m_inst_q = '0, m_data_q = '0;
  logic [3:0]  m_be = '0;
  int          m_grant = 0, m_ack_at = 0, m_free = 1, m_rdy = -10;
  bit          hold_ack = 0, no_new = 0, want_load = 0, want_fetch = 0;
  bit          inst_drop = 0, data_drop = 0;

  task automatic step();
    bit exp_req, w;
    logic [DW-1:0] ad;
    @(posedge clock); #1;
    cyc++;
    exp_req = m_busy && (cyc > m_grant);
    check("mem_req", 64'(bus.Mem_Req), 64'(exp_req));
    if (exp_req) begin
      check("mem_addr", 64'(bus.Mem_Address), 64'(m_addr));
      check("mem_we", 64'(bus.Mem_We), 64'(m_we));
      if (m_tgt_data && m_we) begin
        check("mem_wdata", 64'(bus.Mem_WriteData), 64'(m_wd));
        check("mem_be", 64'(bus.Mem_ByteEn), 64'(m_be));
      end
    end
    check("inst_ready", 64'(bus.InstMem_Ready), 64'(cyc == m_rdy && !m_rdy_data));
    check("data_ready", 64'(bus.DataMem_Ready), 64'(cyc == m_rdy && m_rdy_data));
    if (cyc == m_rdy) begin
      if (m_rdy_data) m_data_q = m_rdy_val;
      else            m_inst_q = m_rdy_val;
    end
    check("inst_data", 64'(bus.InstMem_Data), 64'(m_inst_q));
    check("data_rdata", 64'(bus.DataMem_ReadData), 64'(m_data_q));
    check("mem_error", 64'(bus.Mem_Error), 64'd0);

    // Fetch requester: drops its request the cycle after Ready, may re-raise at once.
    if (inst_drop) bus.InstMem_Read = 1'b0;
    inst_drop = bus.InstMem_Ready;
    if (!bus.InstMem_Read && !inst_drop && (want_fetch || (!no_new && $urandom_range(3) == 0))) begin
      bus.InstMem_Read    = 1'b1;
      bus.InstMem_Address = want_fetch ? AW'(32'h10) : AW'($urandom);
      want_fetch = 0;
    end else if (bus.InstMem_Read && m_busy && !m_tgt_data && cyc > m_grant && $urandom_range(2) == 0) begin
      bus.InstMem_Address = AW'($urandom);
    end

    // Data requester: same protocol; mid-access field changes must be ignored.
    if (data_drop) begin
      bus.DataMem_Read  = 1'b0;
      bus.DataMem_Write = 1'b0;
    end
    data_drop = bus.DataMem_Ready;
    if (!(bus.DataMem_Read || bus.DataMem_Write) && !data_drop &&
        (want_load || (!no_new && $urandom_range(3) == 0))) begin
      w = want_load ? 1'b0 : 1'($urandom_range(1));
      bus.DataMem_Read      = !w;
      bus.DataMem_Write     = w;
      bus.DataMem_Address   = want_load ? AW'(32'h40) : AW'($urandom);
      bus.DataMem_WriteData = $urandom;
      bus.DataMem_ByteEn    = 4'($urandom);
      want_load = 0;
    end else if ((bus.DataMem_Read || bus.DataMem_Write) && m_busy && m_tgt_data &&
                 cyc > m_grant && $urandom_range(2) == 0) begin
      bus.DataMem_Address   = AW'($urandom);
      bus.DataMem_WriteData = $urandom;
      bus.DataMem_ByteEn    = 4'($urandom);
    end

    // Memory: ack the outstanding access after its chosen latency; spurious acks otherwise.
    bus.Mem_Ack      = 1'b0;
    bus.Mem_ReadData = $urandom;
    if (m_busy && cyc > m_grant) begin
      if (!hold_ack && cyc == m_ack_at) begin
        ad = $urandom;
        bus.Mem_Ack      = 1'b1;
        bus.Mem_ReadData = ad;
        m_busy     = 0;
        m_rdy      = cyc + 1;
        m_rdy_data = m_tgt_data;
        m_rdy_val  = (m_tgt_data && m_we) ? '0 : ad;
        m_free     = cyc + 2;
      end
    end else if ($urandom_range(7) == 0) begin
      bus.Mem_Ack = 1'b1;
    end

    // Grant decision from this cycle's requests: data beats fetch.
    if (!m_busy && cyc >= m_free) begin
      if (bus.DataMem_Read || bus.DataMem_Write) begin
        m_busy = 1; m_tgt_data = 1; m_we = bus.DataMem_Write;
        m_addr = bus.DataMem_Address; m_wd = bus.DataMem_WriteData; m_be = bus.DataMem_ByteEn;
      end else if (bus.InstMem_Read) begin
        m_busy = 1; m_tgt_data = 0; m_we = 0; m_addr = bus.InstMem_Address;
      end
      if (m_busy) begin
        m_grant  = cyc;
        m_ack_at = cyc + 1 + int'($urandom_range(3));
      end
    end

    #1;
    check("stall", 64'(bus.MEM_Stall_Controller),
          64'((bus.DataMem_Read || bus.DataMem_Write) && !(cyc == m_rdy && m_rdy_data)));
  endtask

  task automatic quiesce();
    no_new = 1;
    for (int i = 0; i < 60 && (m_busy || bus.InstMem_Read || bus.DataMem_Read || bus.DataMem_Write); i++)
      step();
    repeat (2) step();
    check("quiesce", 64'({m_busy, bus.InstMem_Read, bus.DataMem_Read, bus.DataMem_Write}), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    int req_cycles, rdy_at;
    bus.InstMem_Read = 0; bus.InstMem_Address = '0;
    bus.DataMem_Read = 0; bus.DataMem_Write = 0; bus.DataMem_Address = '0;
    bus.DataMem_WriteData = '0; bus.DataMem_ByteEn = '0;
    bus.Mem_Ack = 0; bus.Mem_ReadData = '0;
    repeat (3) @(negedge clock);

    check("rst_mem_req", 64'(bus.Mem_Req), 64'd0);
    check("rst_mem_we", 64'(bus.Mem_We), 64'd0);
    check("rst_mem_addr", 64'(bus.Mem_Address), 64'd0);
    check("rst_mem_wdata", 64'({bus.Mem_WriteData, bus.Mem_ByteEn}), 64'd0);
    check("rst_readies", 64'({bus.InstMem_Ready, bus.DataMem_Ready}), 64'd0);
    check("rst_datas", 64'({bus.InstMem_Data, bus.DataMem_ReadData}), 64'd0);
    check("rst_error", 64'(bus.Mem_Error), 64'd0);
    check("rst_stall", 64'(bus.MEM_Stall_Controller), 64'd0);
    reset_n = 1'b1;

    // Directed fetch-then-simultaneous start, then random traffic.
    want_fetch = 1;
    repeat (10) step();
    want_fetch = 1; want_load = 1;
    repeat (20) step();
    repeat (1500) step();
    quiesce();

    // Asynchronous reset during a data wait.
    hold_ack = 1; want_load = 1;
    for (int i = 0; i < 10 && !bus.Mem_Req; i++) step();
    check("rst_test_req_up", 64'(bus.Mem_Req), 64'd1);
    repeat (2) step();
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    check("async_rst_req", 64'(bus.Mem_Req), 64'd0);
    check("async_rst_ready", 64'({bus.InstMem_Ready, bus.DataMem_Ready}), 64'd0);
    check("async_rst_stall", 64'(bus.MEM_Stall_Controller), 64'd1);
    bus.DataMem_Read = 0; bus.Mem_Ack = 0;
    @(negedge clock);
    reset_n = 1'b1;
    m_busy = 0; m_rdy = -10; m_inst_q = '0; m_data_q = '0; m_free = cyc + 1;
    hold_ack = 0; inst_drop = 0; data_drop = 0;
    repeat (5) step();
    no_new = 0;
    repeat (200) step();
    quiesce();

`ifdef MEM_ARB_TIMEOUT_EN
    // No ack: abort after TMO wait cycles with a zero-data Ready and sticky error.
    bus.DataMem_Read = 1; bus.DataMem_Address = AW'(32'h40);
    bus.Mem_Ack = 0;
    req_cycles = 0; rdy_at = 0;
    for (int i = 1; i <= 40 && rdy_at == 0; i++) begin
      @(posedge clock); #1;
      if (bus.Mem_Req) req_cycles++;
      if (bus.DataMem_Ready) begin
        rdy_at = i;
        check("tmo_error_at_ready", 64'(bus.Mem_Error), 64'd1);
        check("tmo_rdata", 64'(bus.DataMem_ReadData), 64'd0);
        check("tmo_req_dropped", 64'(bus.Mem_Req), 64'd0);
      end
    end
    check("tmo_ready_seen", 64'(rdy_at != 0), 64'd1);
    check("tmo_req_cycles", 64'(req_cycles), 64'(TMO));
    @(posedge clock); #1;
    bus.DataMem_Read = 0;
    check("tmo_single_ready", 64'(bus.DataMem_Ready), 64'd0);
    repeat (4) @(posedge clock);
    #1;
    check("tmo_error_sticky", 64'(bus.Mem_Error), 64'd1);
`else
    req_cycles = 0; rdy_at = 0;
    check("no_tmo_error", 64'(bus.Mem_Error + req_cycles + rdy_at), 64'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
